mem_word_cache: RTL and testbench
=================================

# mem_word_cache

Direct-mapped, write-through word cache between `cpu_top`'s memory port and the SPI SRAM controller. Read hits return in one cycle instead of a full SPI transaction (~70+ clocks); misses and all writes pass through to the controller using the same req/ready handshake on both sides. The block also provides an invalidate input and hit/miss counters for debug.

## Interface
- `LINES`, 4, number of one-word lines (power of 2, ≥2); `IDX_W = log2(LINES)`, `TAG_W = 16 − IDX_W`.
- `clk` in 1: system clock; every register is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU access request; the CPU holds it high with `cpu_we`/`cpu_addr`/`cpu_wdata` stable until `cpu_ready`.
- `cpu_we` in 1: 1 means write, 0 means read.
- `cpu_addr` in 16: word address.
- `cpu_wdata` in 16: write data.
- `cpu_rdata` out 16: read data; valid only while `cpu_ready` is 1.
- `cpu_ready` out 1: one-cycle completion pulse.
- `mem_req` out 1: request to the SPI controller; held until `mem_ready`.
- `mem_we`, `mem_addr[15:0]`, `mem_wdata[15:0]` out: command to the controller; stable while `mem_req` is 1.
- `mem_rdata` in 16: controller read data; valid in the `mem_ready` cycle.
- `mem_ready` in 1: controller completion pulse.
- `inv` in 1: invalidate-all request (pulse or level).
- `hit_cnt` out 16: read-hit counter.
- `miss_cnt` out 16: read-miss counter.

## Operation
- Address split: `idx = cpu_addr[IDX_W-1:0]`, `tag = cpu_addr[15:IDX_W]`. Each line holds a valid bit, the tag and 16 data bits.
- Registered inputs: `cpu_addr`, `cpu_we` and `cpu_wdata` are captured into request registers when a request is accepted in IDLE.
- FSM states: IDLE, FILL, WTHRU, RESP.
- IDLE:
  - If `inv_pend` is set, clear all valid bits and `inv_pend`, then stay in IDLE. Any request waits for the next cycle.
  - Else, on `cpu_req`, accept the request:
    - read hit (line valid and tag match): load `cpu_rdata` with the line data, increment `hit_cnt`, go to RESP.
    - read miss: increment `miss_cnt`, set `mem_req=1, mem_we=0, mem_addr=cpu_addr`, go to FILL.
    - write: install the line (valid=1, tag, data=`cpu_wdata`; write-allocate), set `mem_req=1, mem_we=1`, go to WTHRU.
- FILL: on `mem_ready`:
  - drop `mem_req`;
  - install the line with `mem_rdata`;
  - set `cpu_rdata = mem_rdata`;
  - go to RESP.
- WTHRU: on `mem_ready`, drop `mem_req` and go to RESP. `cpu_rdata` is not updated.
- RESP: `cpu_ready=1` for exactly this cycle; `cpu_req` is ignored; the next state is always IDLE.
- `inv` sets `inv_pend` in any state. It is applied only in IDLE, so an in-flight fill is never lost mid-transaction; the line installed by that fill is cleared at the next IDLE.
- `mem_ready` in IDLE or RESP is ignored.
- Both counters wrap from 0xFFFF to 0x0000. Writes change neither counter.

## Timing
- Reset values: `cpu_ready=0`, `cpu_rdata=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `hit_cnt=0`, `miss_cnt=0`, all valid bits 0, `inv_pend=0`, state IDLE.
- Reset is asynchronous and can occur mid-transaction: `mem_req` drops immediately and no partial line is retained.
- All outputs are registered. There is no combinational path from any input to any output.
- Read hit: request seen in IDLE at edge T, `cpu_ready` high in cycle T+1, back in IDLE at T+2. Back-to-back hits therefore complete every 2 cycles.
- Miss or write: `mem_req` rises in cycle T+1. If `mem_ready` arrives in cycle M, then `mem_req` is 0 and `cpu_ready` is 1 in cycle M+1.
- The CPU deasserts `cpu_req` or presents a new request after `cpu_ready`. A `cpu_req` still high in the first IDLE cycle after RESP is treated as a new access.
- A write to a line followed by a read of the same address hits and returns the written value.

## Test plan
- Read-miss then read-hit:
  - Reset, memory model holds 0x1234 at 0x0040 with `mem_ready` 5 cycles after `mem_req`.
  - Read 0x0040 → one `mem_req` with `mem_we=0, mem_addr=0x0040`; `cpu_rdata=0x1234` with `cpu_ready` one cycle after `mem_ready`; `miss_cnt=1`.
  - Read 0x0040 again → `cpu_ready` at T+1, no `mem_req`, `hit_cnt=1`.
- Conflict: read 0x0001 then 0x0005 (LINES=4, same index) → both miss. Re-reading 0x0001 misses again; `miss_cnt=3`.
- Write-through: write 0xBEEF to 0x0102 → `mem_req` with `mem_we=1, mem_wdata=0xBEEF`, `cpu_ready` after `mem_ready`. A following read of 0x0102 hits with 0xBEEF; counters show `hit_cnt=1`, `miss_cnt=0`.
- Invalidate: pulse `inv` during a FILL → the fill completes and returns data normally. A re-read of the same address misses (`mem_req` issued).
- Reset mid-FILL: drop `rst_n` while `mem_req=1` → `mem_req`, `cpu_ready` and the counters are 0 immediately. After release, a read of the previously filled address misses.
- Counter wrap: preload 65535 read hits (or force `hit_cnt=0xFFFF`) then perform one hit → `hit_cnt=0x0000`.

Source files
------------

// File: rtl/mem_word_cache.sv
// Direct-mapped write-through word cache between the CPU port
// and the SPI SRAM controller, with invalidate and hit/miss counters.
module mem_word_cache #(
  parameter  int LINES = 4,
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = 16 - IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        inv,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WTHRU,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic             r_valid [LINES];
  logic [TAG_W-1:0] r_tag   [LINES];
  logic [15:0]      r_data  [LINES];

  logic        r_inv_pend;
  logic        r_ready;
  logic [15:0] r_rdata;
  logic        r_mreq;
  logic        r_mwe;
  logic [15:0] r_maddr;
  logic [15:0] r_mwdata;
  logic [15:0] r_hit;
  logic [15:0] r_miss;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;

  logic             w_pend_n;
  logic             w_ready_n;
  logic [15:0]      w_rdata_n;
  logic             w_mreq_n;
  logic             w_mwe_n;
  logic [15:0]      w_maddr_n;
  logic [15:0]      w_mwdata_n;
  logic [15:0]      w_hit_n;
  logic [15:0]      w_miss_n;
  logic             w_clr_all;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;
  logic [15:0]      w_wr_data;

  assign w_idx = cpu_addr[IDX_W-1:0];
  assign w_tag = cpu_addr[15:IDX_W];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!r_inv_pend && cpu_req) begin
          unique case (1'b1)
            cpu_we:  w_state_n = S_WTHRU;
            w_hit:   w_state_n = S_RESP;
            default: w_state_n = S_FILL;
          endcase
        end
      end
      S_FILL:  if (mem_ready) w_state_n = S_RESP;
      S_WTHRU: if (mem_ready) w_state_n = S_RESP;
      S_RESP:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_pend_n   = r_inv_pend | inv;
    w_ready_n  = 1'b0;
    w_rdata_n  = r_rdata;
    w_mreq_n   = r_mreq;
    w_mwe_n    = r_mwe;
    w_maddr_n  = r_maddr;
    w_mwdata_n = r_mwdata;
    w_hit_n    = r_hit;
    w_miss_n   = r_miss;
    w_clr_all  = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_idx   = w_idx;
    w_wr_tag   = w_tag;
    w_wr_data  = cpu_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (r_inv_pend) begin
          w_clr_all = 1'b1;
          w_pend_n  = inv;
        end else if (cpu_req) begin
          w_mwe_n    = cpu_we;
          w_maddr_n  = cpu_addr;
          w_mwdata_n = cpu_wdata;
          unique case (1'b1)
            cpu_we: begin
              w_wr_en  = 1'b1;
              w_mreq_n = 1'b1;
            end
            w_hit: begin
              w_rdata_n = r_data[w_idx];
              w_hit_n   = r_hit + 16'd1;
              w_ready_n = 1'b1;
            end
            default: begin
              w_miss_n = r_miss + 16'd1;
              w_mreq_n = 1'b1;
            end
          endcase
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          w_mreq_n  = 1'b0;
          w_wr_en   = 1'b1;
          w_wr_idx  = r_maddr[IDX_W-1:0];
          w_wr_tag  = r_maddr[15:IDX_W];
          w_wr_data = mem_rdata;
          w_rdata_n = mem_rdata;
          w_ready_n = 1'b1;
        end
      end
      S_WTHRU: begin
        if (mem_ready) begin
          w_mreq_n  = 1'b0;
          w_ready_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inv_pend <= 1'b0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_mreq     <= 1'b0;
      r_mwe      <= 1'b0;
      r_maddr    <= '0;
      r_mwdata   <= '0;
      r_hit      <= '0;
      r_miss     <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_data[i]  <= '0;
      end
    end else begin
      r_inv_pend <= w_pend_n;
      r_ready    <= w_ready_n;
      r_rdata    <= w_rdata_n;
      r_mreq     <= w_mreq_n;
      r_mwe      <= w_mwe_n;
      r_maddr    <= w_maddr_n;
      r_mwdata   <= w_mwdata_n;
      r_hit      <= w_hit_n;
      r_miss     <= w_miss_n;
      if (w_clr_all) begin
        for (int i = 0; i < LINES; i++) begin
          r_valid[i] <= 1'b0;
        end
      end else if (w_wr_en) begin
        r_valid[w_wr_idx] <= 1'b1;
        r_tag[w_wr_idx]   <= w_wr_tag;
        r_data[w_wr_idx]  <= w_wr_data;
      end
    end
  end

  assign cpu_ready = r_ready;
  assign cpu_rdata = r_rdata;
  assign mem_req   = r_mreq;
  assign mem_we    = r_mwe;
  assign mem_addr  = r_maddr;
  assign mem_wdata = r_mwdata;
  assign hit_cnt   = r_hit;
  assign miss_cnt  = r_miss;

endmodule

// File: tb/tb_mem_word_cache.sv
// Directed bench for mem_word_cache: vector table of accesses
// plus hand sequences for reset-mid-fill and counter wrap.
module tb_mem_word_cache;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        inv;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int n_cmp;
  int n_bad;

  mem_word_cache #(.LINES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .inv(inv), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    int          inv_at;
    logic [15:0] exp_rd;
    int          exp_nreq;
    int          exp_lat;
    logic [15:0] exp_hit;
    logic [15:0] exp_miss;
  } vec_t;

  typedef struct {
    logic [15:0] rd;
    int          nreq;
    int          lat;
    logic [15:0] maddr;
    logic        mwe;
    logic [15:0] mwd;
    bit          rdy_mreq;
  } res_t;

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return (a == 16'h0040) ? 16'h1234 : (a ^ 16'hC3C3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // lat = cycles mem_req is high before the mem_ready cycle
  task automatic access(input logic we, input logic [15:0] a,
                        input logic [15:0] wd, input int lat,
                        input int inv_at, output res_t r);
    int  mcnt;
    bit  done;
    r = '{rd: 16'h0, nreq: 0, lat: -1, maddr: 16'h0,
          mwe: 1'b0, mwd: 16'h0, rdy_mreq: 1'b0};
    mcnt = 0;
    done = 0;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = wd;
    for (int t = 1; t <= 200 && !done; t++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 16'hDEAD;
      inv = (t == inv_at);
      if (cpu_ready) begin
        r.rd = cpu_rdata;
        r.lat = t;
        r.rdy_mreq = mem_req;
        done = 1;
      end else if (mem_req) begin
        if (mcnt == 0) begin
          r.nreq++;
          r.maddr = mem_addr;
          r.mwe = mem_we;
          r.mwd = mem_wdata;
        end
        mcnt++;
        if (mcnt == lat + 1) begin
          mem_ready = 1'b1;
          mem_rdata = mem_model(mem_addr);
        end
      end
    end
    cpu_req = 1'b0;
    inv = 1'b0;
    mem_ready = 1'b0;
  endtask

  vec_t vt [14];
  res_t r;
  bit   seen;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = 16'h0;
    cpu_wdata = 16'h0;
    mem_rdata = 16'h0;
    mem_ready = 1'b0;
    inv = 1'b0;

    vt[0]  = '{0, 16'h0040, 0, 5, 0, 16'h1234, 1, 7, 0, 1};
    vt[1]  = '{0, 16'h0040, 0, 1, 0, 16'h1234, 0, 1, 1, 1};
    vt[2]  = '{0, 16'h0001, 0, 2, 0, 16'hC3C2, 1, 4, 1, 2};
    vt[3]  = '{0, 16'h0005, 0, 2, 0, 16'hC3C6, 1, 4, 1, 3};
    vt[4]  = '{0, 16'h0001, 0, 1, 0, 16'hC3C2, 1, 3, 1, 4};
    vt[5]  = '{1, 16'h0102, 16'hBEEF, 3, 0, 0, 1, 5, 1, 4};
    vt[6]  = '{0, 16'h0102, 0, 1, 0, 16'hBEEF, 0, 1, 2, 4};
    vt[7]  = '{0, 16'h0040, 0, 1, 0, 16'h1234, 0, 1, 3, 4};
    vt[8]  = '{1, 16'h0006, 16'h5555, 0, 0, 0, 1, 2, 3, 4};
    vt[9]  = '{0, 16'h0006, 0, 1, 0, 16'h5555, 0, 1, 4, 4};
    vt[10] = '{0, 16'h0102, 0, 2, 0, 16'hC2C1, 1, 4, 4, 5};
    vt[11] = '{0, 16'h0003, 0, 3, 2, 16'hC3C0, 1, 5, 4, 6};
    vt[12] = '{0, 16'h0003, 0, 1, 0, 16'hC3C0, 1, 4, 4, 7};
    vt[13] = '{0, 16'h0040, 0, 1, 0, 16'h1234, 1, 3, 4, 8};

    repeat (2) @(negedge clk);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      access(vt[i].we, vt[i].addr, vt[i].wdata,
             vt[i].lat, vt[i].inv_at, r);
      if (!vt[i].we) chk($sformatf("v%0d_rdata", i), r.rd, vt[i].exp_rd);
      chk($sformatf("v%0d_nreq", i), r.nreq, vt[i].exp_nreq);
      chk($sformatf("v%0d_lat", i), r.lat, vt[i].exp_lat);
      chk($sformatf("v%0d_req_at_rdy", i), r.rdy_mreq, 0);
      if (vt[i].exp_nreq == 1) begin
        chk($sformatf("v%0d_mem_addr", i), r.maddr, vt[i].addr);
        chk($sformatf("v%0d_mem_we", i), r.mwe, vt[i].we);
        if (vt[i].we)
          chk($sformatf("v%0d_mem_wdata", i), r.mwd, vt[i].wdata);
      end
      chk($sformatf("v%0d_hit_cnt", i), hit_cnt, vt[i].exp_hit);
      chk($sformatf("v%0d_miss_cnt", i), miss_cnt, vt[i].exp_miss);
    end

    access(0, 16'h0040, 0, 1, 0, r);
    chk("pre_rst_hit", r.nreq, 0);
    chk("pre_rst_hit_cnt", hit_cnt, 5);

    @(negedge clk);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 16'h0007;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    chk("midfill_req_seen", seen, 1);
    chk("midfill_miss_cnt", miss_cnt, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_cpu_ready", cpu_ready, 0);
    chk("async_rst_hit_cnt", hit_cnt, 0);
    chk("async_rst_miss_cnt", miss_cnt, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    access(0, 16'h0040, 0, 1, 0, r);
    chk("post_rst_nreq", r.nreq, 1);
    chk("post_rst_rdata", r.rd, 16'h1234);
    chk("post_rst_miss_cnt", miss_cnt, 1);
    access(0, 16'h0040, 0, 1, 0, r);
    chk("post_rst_hit_lat", r.lat, 1);
    chk("post_rst_hit_cnt", hit_cnt, 1);

    @(negedge clk);
    force dut.r_hit = 16'hFFFF;
    @(negedge clk);
    release dut.r_hit;
    chk("preload_hit_cnt", hit_cnt, 16'hFFFF);
    access(0, 16'h0040, 0, 1, 0, r);
    chk("wrap_hit_rdata", r.rd, 16'h1234);
    chk("wrap_hit_cnt", hit_cnt, 16'h0000);
    access(0, 16'h0040, 0, 1, 0, r);
    chk("after_wrap_hit_cnt", hit_cnt, 16'h0001);
    chk("after_wrap_miss_cnt", miss_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
